// File: rtl/adder_2bit_sweeper_pkg.sv
// Shared definitions for the adder_2bit self-test sweeper: FSM encoding and sweep size.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Number of {A,B} operand pairs for a given operand width.
  function automatic int VEC_COUNT(input int width);
    return 1 << (2 * width);
  endfunction

endpackage

// File: rtl/adder_2bit_sweeper_if.sv
// Bus between the sweeper, the adder under test and whoever reads the results.
interface adder_2bit_sweeper_if #(parameter int WIDTH = 2);
  logic                 Start;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [WIDTH-1:0]     Sum;
  logic                 Carry;
  logic                 Busy;
  logic                 Done;
  logic [2*WIDTH:0]     PassCount;
  logic [2*WIDTH:0]     FailCount;
  logic                 FailValid;
  logic [2*WIDTH-1:0]   FirstFailVec;

  modport master (
    input  Start, Sum, Carry,
    output A, B, Busy, Done, PassCount, FailCount, FailValid, FirstFailVec
  );

  modport slave (
    output Start, Sum, Carry,
    input  A, B, Busy, Done, PassCount, FailCount, FailValid, FirstFailVec
  );
endinterface

// File: rtl/adder_2bit_sweeper_settle.sv
// Loadable 4-bit down-counter that times how long each vector is held.
module sweep_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);
  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                     cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != 4'd0) cnt <= cnt - 4'd1;
  end

  assign zero = (cnt == 4'd0);
endmodule

// File: rtl/adder_2bit_sweeper.sv
// Exhaustive {A,B} sweep of an external adder: drive, settle, sample, tally.
import adder_pkg::*;

module adder_2bit_sweeper #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 2
) (
  input logic                  Clk,
  input logic                  Rst,
  adder_2bit_sweeper_if.master bus
);
  localparam int VW = 2 * WIDTH;
  localparam int CW = $clog2(VEC_COUNT(WIDTH)) + 1;

  state_t          state, state_nxt;
  logic [VW-1:0]   vec;
  logic [CW-1:0]   pass_cnt, fail_cnt;
  logic            fail_vld;
  logic [VW-1:0]   first_fail;
  logic            go, last, match, tmr_load, tmr_zero;

  assign go       = bus.Start && (state == IDLE || state == DONE);
  assign last     = (vec == VW'(VEC_COUNT(WIDTH) - 1));
  assign match    = ({bus.Carry, bus.Sum} ==
                     ({1'b0, vec[VW-1:WIDTH]} + {1'b0, vec[WIDTH-1:0]}));
  assign tmr_load = go || (state == SAMPLE && !last);

  sweep_settle_timer u_settle (
    .clk      (Clk),
    .rst      (Rst),
    .load     (tmr_load),
    .load_val (4'(SETTLE - 1)),
    .dec      (state == DRIVE),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.Start) state_nxt = DRIVE;
      DRIVE:      if (tmr_zero)  state_nxt = SAMPLE;
      SAMPLE:     state_nxt = last ? DONE : DRIVE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A start from IDLE or DONE wipes the previous sweep's results on the same edge.
  always_ff @(posedge Clk) begin
    if (Rst || go) begin
      vec        <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      fail_vld   <= 1'b0;
      first_fail <= '0;
    end else if (state == SAMPLE) begin
      if (match) pass_cnt <= pass_cnt + 1'b1;
      else begin
        fail_cnt <= fail_cnt + 1'b1;
        if (!fail_vld) begin
          fail_vld   <= 1'b1;
          first_fail <= vec;
        end
      end
      if (!last) vec <= vec + 1'b1;
    end
  end

  assign bus.A            = vec[VW-1:WIDTH];
  assign bus.B            = vec[WIDTH-1:0];
  assign bus.Busy         = (state == DRIVE) || (state == SAMPLE);
  assign bus.Done         = (state == DONE);
  assign bus.PassCount    = pass_cnt;
  assign bus.FailCount    = fail_cnt;
  assign bus.FailValid    = fail_vld;
  assign bus.FirstFailVec = first_fail;
endmodule

// File: doc/adder_2bit_sweeper.md
Name: adder_2bit_sweeper

Overview:
Synthesizable self-test sequencer that sits directly upstream of adder_2bit. It drives every {A,B} operand pair and holds each pair for a programmable settle time. It then samples {Carry,Sum} back from the adder, checks the result against A+B and tallies passes and failures. It replaces hand-written directed vectors with an exhaustive hardware sweep.

Parameters:
WIDTH, 2, operand width of A and B; the sweep covers 2^(2*WIDTH) vectors.
SETTLE, 2, cycles each vector is held before sampling; legal range 1..15.

Ports:
Clk  in  1  system clock, rising edge.
Rst  in  1  synchronous, active-high reset.
Start  in  1  one-cycle pulse that begins a sweep; honoured only in IDLE or DONE.
A  out  WIDTH  operand A to adder_2bit; registered.
B  out  WIDTH  operand B to adder_2bit; registered.
Sum  in  WIDTH  sum returned by adder_2bit.
Carry  in  1  carry returned by adder_2bit.
Busy  out  1  high while in DRIVE or SAMPLE.
Done  out  1  high in DONE; held until Start or Rst.
PassCount  out  2*WIDTH+1  vectors that matched.
FailCount  out  2*WIDTH+1  vectors that mismatched.
FailValid  out  1  set on the first mismatch of a sweep.
FirstFailVec  out  2*WIDTH  {A,B} of the first mismatch.

Behaviour:
- Reset: Rst is synchronous and active-high. It forces state IDLE and clears A, B, Busy, Done, PassCount, FailCount, FailValid and FirstFailVec to 0. Rst overrides Start in the same cycle and aborts a sweep in progress with no partial results kept.
- States:
  - IDLE: Start=1 moves to DRIVE. On that edge vec=0, {A,B}=0, the counts and fail fields are cleared, and the settle counter loads SETTLE-1.
  - DRIVE: the settle counter decrements each cycle. When it reaches 0, move to SAMPLE. DRIVE lasts exactly SETTLE cycles.
  - SAMPLE: lasts one cycle.
    - Compare {Carry,Sum} against the zero-extended A+B, which is WIDTH+1 bits wide.
    - On a match, PassCount++. On a mismatch, FailCount++; if FailValid=0, set FailValid=1 and capture FirstFailVec={A,B}.
    - If vec is all ones, move to DONE. Otherwise vec++, drive {A,B}=vec, reload the settle counter with SETTLE-1 and return to DRIVE.
  - DONE: Done=1. A and B hold the last vector. Start=1 restarts exactly as from IDLE, clearing results on that edge.
- Start during DRIVE or SAMPLE is ignored.
- Vector order: {A,B} counts upward from 0 to 2^(2*WIDTH)-1, with B as the low bits.
- Timing: each vector takes SETTLE+1 cycles. If Start is sampled at edge k, Done is first visible after edge k+2^(2*WIDTH)*(SETTLE+1); for the defaults that is k+48.
- Counters are wide enough to hold 2^(2*WIDTH), so they never wrap.
- PassCount+FailCount always equals the number of vectors sampled so far in the current sweep.
- The Sum/Carry inputs are treated as combinational returns of the current A/B.

Decomposition:
- Shared package adder_pkg holds:
  - the state encoding localparams IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, DONE=2'd3;
  - the VEC_COUNT function of WIDTH.
- One natural sub-module: sweep_settle_timer, a loadable 4-bit down-counter with a zero flag.
- The comparator and tally logic stay in the top module.

Test Plan:
- Golden adder model connected, Start pulse -> Busy=1 for 48 cycles; Done=1 at edge k+48; PassCount=16, FailCount=0, FailValid=0; A and B hold 2'b11.
- Faulty model with Carry stuck at 0 -> PassCount=10, FailCount=6, FailValid=1, FirstFailVec=4'b0111 (A=1, B=3).
- Rst asserted for 1 cycle mid-sweep while vec=5 -> next cycle state is IDLE and all outputs are 0; a later Start completes a full sweep normally.
- Start pulsed repeatedly while Busy=1 -> no restart, and Done still arrives at edge k+48.
- Start in DONE after the faulty run, then golden model swapped in -> counts clear on the Start edge; final PassCount=16, FailCount=0, FailValid=0.
- Start and Rst high in the same cycle -> reset wins; state remains IDLE and Busy=0.
